board_render_fsm: RTL and testbench
===================================

# board_render_fsm

Parametrised game-board renderer: the successor to the fixed 16×16, two-player board FSM. On `start` it does three things. It erases each player's previous tile in tile memory and writes each player's current tile, marking collisions. It then raster-draws every tile of a GRID_W×GRID_H board as TILE_PX×TILE_PX pixel squares to the VGA plot interface, once per animation frame, for NUM_FRAMES frames with a FRAME_CYCLES hold after each. It sits between the player FSMs and the dual-port tile BRAM, which uses port A for writes and port B for reads, and drives the VGA adapter directly.

## Interface
- GRID_W, 16, board columns
- GRID_H, 16, board rows
- COORD_W, 4, width of each player coordinate
- ADDR_W, 8, tile address width (≥ clog2(GRID_W*GRID_H))
- TILE_PX, 10, tile edge in pixels
- NUM_PLAYERS, 2, player channels (≥1)
- NUM_FRAMES, 5, animation frames per sequence (≥1)
- FRAME_CYCLES, 416666, hold cycles after each frame (≥1)
- ORIGIN_X, 0 / ORIGIN_Y, 0, pixel origin of tile (0,0)
- BG_COLOUR, 3'b000; COLLIDE_COLOUR, 3'b111
- clock  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-high
- start  in  1  begin a sequence; sampled only in IDLE
- player_x / player_y  in  NUM_PLAYERS*COORD_W  player i at [i*COORD_W +: COORD_W]
- player_colour  in  NUM_PLAYERS*3  player i at [i*3 +: 3]
- wr_en  out  1; wr_addr  out  ADDR_W; wr_data  out  3  BRAM port A
- rd_en  out  1; rd_addr  out  ADDR_W  BRAM port B
- rd_data  in  3  port B data, valid exactly one cycle after rd_en
- x  out  10; y  out  9; colour  out  3; plot  out  1  VGA pixel write
- frame_index  out  clog2(NUM_FRAMES+1)  current frame, for foreground overlay
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at sequence end

## Operation
- Tile address = y*GRID_W + x. A player is valid iff x<GRID_W and y<GRID_H.
- IDLE: all strobes low. A `start` seen at a rising edge moves the FSM to LATCH. `start` is ignored in every other state.
- LATCH (1 cycle): registers all player inputs. Input changes after this cycle have no effect until the next sequence.
- ERASE (NUM_PLAYERS cycles, player i in cycle i): wr_en=1, wr_addr=prev_addr[i], wr_data=BG_COLOUR. The write is suppressed (wr_en=0) if prev_valid[i]=0.
- WRITE (NUM_PLAYERS cycles, player i in cycle i): wr_en=valid[i], wr_addr=addr[i]. wr_data=COLLIDE_COLOUR if another valid player j≠i has the same address, else player_colour[i]. The cycle then updates prev_addr[i] and prev_valid[i]. ERASE always precedes WRITE, so a player that has not moved is rewritten.
- FETCH (1 cycle): rd_en=1, rd_addr=tile.
- LOAD (1 cycle): registers rd_data as the tile colour.
- DRAW (TILE_PX² cycles): plot=1. x = ORIGIN_X + col*TILE_PX + px and y = ORIGIN_Y + row*TILE_PX + py, where col = tile mod GRID_W and row = tile div GRID_W. px runs fastest, 0..TILE_PX-1, then py increments. colour is the tile colour. On the last pixel the FSM goes to FETCH for tile+1, or to HOLD after tile GRID_W*GRID_H-1.
- HOLD (FRAME_CYCLES cycles): plot=0. On exit frame_index increments. If the new frame_index < NUM_FRAMES the FSM goes to FETCH at tile 0, else to DONE.
- DONE (1 cycle): done=1, then IDLE. frame_index returns to 0 on entering IDLE.
- Write ports and read ports are never active in the same cycle.

## Timing
- Reset (async, any state): state IDLE. All outputs 0: wr_*, rd_*, x, y, colour, plot, frame_index, busy, done. All prev_valid cleared; prev_addr cleared.
- `start` high at edge k: LATCH in cycle k+1, first ERASE in k+2, first FETCH in k+2+2·NUM_PLAYERS.
- Per tile: 2 + TILE_PX² cycles. Per frame: GRID_W·GRID_H·(2+TILE_PX²) + FRAME_CYCLES cycles.
- Sequence length from LATCH to DONE inclusive: 2 + 2·NUM_PLAYERS + NUM_FRAMES·per-frame.
- Outputs are driven from registers only, with no combinational path from the inputs. x, y and colour are meaningful only while plot=1.
- Counter widths are sized from the parameters. The pixel and tile counters wrap only at their terminal values, never at their natural width.

## Test plan
Bench parameters: GRID_W=GRID_H=4, TILE_PX=2, NUM_PLAYERS=2, NUM_FRAMES=2, FRAME_CYCLES=8.

1. **Basic sequence.** P0=(1,0) red, P1=(2,3) blue; pulse `start`. Required: writes 1←100 and 14←001. Then 2 frames of 16 tiles × 4 plots each (128 plots total). done pulses exactly 2+4+2·(16·6+8)=214 cycles after LATCH begins.
2. **Collision.** Both players at (3,3). Required: two writes to address 15, both 111. All 4 pixels at x∈{6,7}, y∈{6,7} have colour 111.
3. **Movement erase.** After scenario 1, move P0 to (0,0) and restart. Required: first ERASE writes 1←000 and 14←000, then WRITE writes 0←100 and 14←001.
4. **Out-of-range player.** P1=(4,0). Required: no write for P1. No collision is flagged even if P0 sits at address 4. The next sequence's ERASE skips P1.
5. **Reset mid-DRAW.** Assert reset while plot=1 in frame 1. Required: all outputs 0 in the same cycle (asynchronous). No further plots until a new `start`. The next ERASE writes nothing.
6. **Start during busy.** Hold `start` high for the whole sequence. Required: exactly one LATCH per sequence. The second sequence begins one cycle after IDLE is re-entered.

Source files
------------

// File: rtl/board_render_fsm.sv
// Tile-board renderer: updates player tiles in BRAM, then rasters the board
// to the VGA plot interface for NUM_FRAMES frames with a hold after each.
module board_render_fsm #(
  parameter int GRID_W       = 16,
  parameter int GRID_H       = 16,
  parameter int COORD_W      = 4,
  parameter int ADDR_W       = 8,
  parameter int TILE_PX      = 10,
  parameter int NUM_PLAYERS  = 2,
  parameter int NUM_FRAMES   = 5,
  parameter int FRAME_CYCLES = 416666,
  parameter int ORIGIN_X     = 0,
  parameter int ORIGIN_Y     = 0,
  parameter logic [2:0] BG_COLOUR      = 3'b000,
  parameter logic [2:0] COLLIDE_COLOUR = 3'b111
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [NUM_PLAYERS*COORD_W-1:0]    player_x,
  input  logic [NUM_PLAYERS*COORD_W-1:0]    player_y,
  input  logic [NUM_PLAYERS*3-1:0]          player_colour,
  output logic                              wr_en,
  output logic [ADDR_W-1:0]                 wr_addr,
  output logic [2:0]                        wr_data,
  output logic                              rd_en,
  output logic [ADDR_W-1:0]                 rd_addr,
  input  logic [2:0]                        rd_data,
  output logic [9:0]                        x,
  output logic [8:0]                        y,
  output logic [2:0]                        colour,
  output logic                              plot,
  output logic [$clog2(NUM_FRAMES+1)-1:0]   frame_index,
  output logic                              busy,
  output logic                              done
);

  // state | meaning
  // IDLE  | waiting for start
  // LATCH | capture player inputs
  // ERASE | clear previous tile of player p
  // WRITE | write current tile of player p
  // FETCH | read tile colour from BRAM
  // LOAD  | capture BRAM read data
  // DRAW  | plot TILE_PX x TILE_PX pixels
  // HOLD  | frame hold down-count
  // DONE  | one-cycle completion pulse
  typedef enum logic [3:0] {
    S_IDLE, S_LATCH, S_ERASE, S_WRITE, S_FETCH, S_LOAD, S_DRAW, S_HOLD, S_DONE
  } state_t;

  localparam int FI_W  = $clog2(NUM_FRAMES+1);
  localparam int P_W   = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int PX_W  = (TILE_PX > 1) ? $clog2(TILE_PX) : 1;
  localparam int COL_W = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int ROW_W = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int HC_W  = $clog2(FRAME_CYCLES+1);

  state_t             state_q, state_d;
  logic [P_W-1:0]     p_q, p_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [PX_W-1:0]    px_q, px_d, py_q, py_d;
  logic [HC_W-1:0]    hold_q, hold_d;
  logic [FI_W-1:0]    frame_q, frame_d;
  logic [2:0]         tile_colour_q, tile_colour_d;

  logic [COORD_W-1:0] lat_x_q [NUM_PLAYERS], lat_x_d [NUM_PLAYERS];
  logic [COORD_W-1:0] lat_y_q [NUM_PLAYERS], lat_y_d [NUM_PLAYERS];
  logic [2:0]         lat_c_q [NUM_PLAYERS], lat_c_d [NUM_PLAYERS];
  logic [ADDR_W-1:0]  prev_addr_q [NUM_PLAYERS], prev_addr_d [NUM_PLAYERS];
  logic               prev_valid_q [NUM_PLAYERS], prev_valid_d [NUM_PLAYERS];

  logic               valid   [NUM_PLAYERS];
  logic [ADDR_W-1:0]  addr    [NUM_PLAYERS];
  logic               collide [NUM_PLAYERS];

  logic               wr_en_q, wr_en_d, rd_en_q, rd_en_d, plot_q, plot_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [2:0]         wr_data_q, wr_data_d, colour_q, colour_d;
  logic [9:0]         x_q, x_d;
  logic [8:0]         y_q, y_d;

  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      valid[i] = (int'(lat_x_q[i]) < GRID_W) && (int'(lat_y_q[i]) < GRID_H);
      addr[i]  = ADDR_W'(int'(lat_y_q[i]) * GRID_W + int'(lat_x_q[i]));
    end
  end

  // Only valid players can collide; an out-of-range coordinate may alias a real address.
  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      collide[i] = 1'b0;
      for (int j = 0; j < NUM_PLAYERS; j++)
        if (j != i && valid[i] && valid[j] && addr[i] == addr[j]) collide[i] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;  p_d = p_q;  col_d = col_q;  row_d = row_q;
    px_d = px_q;  py_d = py_q;  hold_d = hold_q;  frame_d = frame_q;
    tile_colour_d = tile_colour_q;
    lat_x_d = lat_x_q;  lat_y_d = lat_y_q;  lat_c_d = lat_c_q;
    prev_addr_d = prev_addr_q;  prev_valid_d = prev_valid_q;

    case (state_q)
      S_IDLE: if (start) state_d = S_LATCH;
      S_LATCH: begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          lat_x_d[i] = player_x[i*COORD_W +: COORD_W];
          lat_y_d[i] = player_y[i*COORD_W +: COORD_W];
          lat_c_d[i] = player_colour[i*3 +: 3];
        end
        p_d = '0;
        state_d = S_ERASE;
      end
      S_ERASE: begin
        if (p_q == P_W'(NUM_PLAYERS-1)) begin
          p_d = '0;
          state_d = S_WRITE;
        end else p_d = p_q + P_W'(1);
      end
      S_WRITE: begin
        prev_valid_d[p_q] = valid[p_q];
        prev_addr_d[p_q]  = addr[p_q];
        if (p_q == P_W'(NUM_PLAYERS-1)) begin
          p_d = '0;  col_d = '0;  row_d = '0;
          state_d = S_FETCH;
        end else p_d = p_q + P_W'(1);
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        tile_colour_d = rd_data;
        px_d = '0;  py_d = '0;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        if (px_q == PX_W'(TILE_PX-1)) begin
          px_d = '0;
          if (py_q == PX_W'(TILE_PX-1)) begin
            py_d = '0;
            if (col_q == COL_W'(GRID_W-1)) begin
              col_d = '0;
              if (row_q == ROW_W'(GRID_H-1)) begin
                row_d = '0;
                hold_d = HC_W'(FRAME_CYCLES-1);
                state_d = S_HOLD;
              end else begin
                row_d = row_q + ROW_W'(1);
                state_d = S_FETCH;
              end
            end else begin
              col_d = col_q + COL_W'(1);
              state_d = S_FETCH;
            end
          end else py_d = py_q + PX_W'(1);
        end else px_d = px_q + PX_W'(1);
      end
      S_HOLD: begin
        if (hold_q == '0) begin
          frame_d = frame_q + FI_W'(1);
          state_d = (int'(frame_q) + 1 < NUM_FRAMES) ? S_FETCH : S_DONE;
        end else hold_d = hold_q - HC_W'(1);
      end
      S_DONE: begin
        frame_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are precomputed from the next state so they register in step with it.
    wr_en_d = 1'b0;  wr_addr_d = '0;  wr_data_d = '0;
    rd_en_d = 1'b0;  rd_addr_d = '0;
    plot_d = 1'b0;  x_d = '0;  y_d = '0;  colour_d = '0;
    case (state_d)
      S_ERASE: begin
        wr_en_d   = prev_valid_q[p_d];
        wr_addr_d = prev_addr_q[p_d];
        wr_data_d = BG_COLOUR;
      end
      S_WRITE: begin
        wr_en_d   = valid[p_d];
        wr_addr_d = addr[p_d];
        wr_data_d = collide[p_d] ? COLLIDE_COLOUR : lat_c_q[p_d];
      end
      S_FETCH: begin
        rd_en_d   = 1'b1;
        rd_addr_d = ADDR_W'(int'(row_d) * GRID_W + int'(col_d));
      end
      S_DRAW: begin
        plot_d   = 1'b1;
        x_d      = 10'(ORIGIN_X + int'(col_d) * TILE_PX + int'(px_d));
        y_d      = 9'(ORIGIN_Y + int'(row_d) * TILE_PX + int'(py_d));
        colour_d = tile_colour_d;
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;  p_q <= '0;  col_q <= '0;  row_q <= '0;
      px_q <= '0;  py_q <= '0;  hold_q <= '0;  frame_q <= '0;
      tile_colour_q <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        lat_x_q[i] <= '0;  lat_y_q[i] <= '0;  lat_c_q[i] <= '0;
        prev_addr_q[i] <= '0;  prev_valid_q[i] <= 1'b0;
      end
      wr_en_q <= 1'b0;  wr_addr_q <= '0;  wr_data_q <= '0;
      rd_en_q <= 1'b0;  rd_addr_q <= '0;
      plot_q <= 1'b0;  x_q <= '0;  y_q <= '0;  colour_q <= '0;
      busy_q <= 1'b0;  done_q <= 1'b0;
    end else begin
      state_q <= state_d;  p_q <= p_d;  col_q <= col_d;  row_q <= row_d;
      px_q <= px_d;  py_q <= py_d;  hold_q <= hold_d;  frame_q <= frame_d;
      tile_colour_q <= tile_colour_d;
      lat_x_q <= lat_x_d;  lat_y_q <= lat_y_d;  lat_c_q <= lat_c_d;
      prev_addr_q <= prev_addr_d;  prev_valid_q <= prev_valid_d;
      wr_en_q <= wr_en_d;  wr_addr_q <= wr_addr_d;  wr_data_q <= wr_data_d;
      rd_en_q <= rd_en_d;  rd_addr_q <= rd_addr_d;
      plot_q <= plot_d;  x_q <= x_d;  y_q <= y_d;  colour_q <= colour_d;
      busy_q <= busy_d;  done_q <= done_d;
    end
  end

  assign wr_en = wr_en_q;   assign wr_addr = wr_addr_q;  assign wr_data = wr_data_q;
  assign rd_en = rd_en_q;   assign rd_addr = rd_addr_q;
  assign plot = plot_q;     assign x = x_q;  assign y = y_q;  assign colour = colour_q;
  assign frame_index = frame_q;
  assign busy = busy_q;     assign done = done_q;

endmodule

// File: tb/tb_board_render_fsm.sv
// Directed bench for board_render_fsm on a 4x4 board, 2x2-pixel tiles, 2 frames.
module tb_board_render_fsm;
  localparam int GW = 4, GH = 4, TP = 2, NP = 2, NF = 2, FC = 8;
  localparam int SEQ_LEN = 2 + 2*NP + NF*(GW*GH*(2 + TP*TP) + FC);
  localparam int PLOTS   = NF*GW*GH*TP*TP;

  logic clock = 1'b0, reset, start;
  logic [7:0] player_x, player_y;
  logic [5:0] player_colour;
  logic wr_en, rd_en, plot, busy, done;
  logic [3:0] wr_addr, rd_addr;
  logic [2:0] wr_data, rd_data, colour;
  logic [9:0] x;
  logic [8:0] y;
  logic [1:0] frame_index;

  board_render_fsm #(
    .GRID_W(GW), .GRID_H(GH), .COORD_W(4), .ADDR_W(4), .TILE_PX(TP),
    .NUM_PLAYERS(NP), .NUM_FRAMES(NF), .FRAME_CYCLES(FC),
    .ORIGIN_X(0), .ORIGIN_Y(0), .BG_COLOUR(3'b000), .COLLIDE_COLOUR(3'b111)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .player_x(player_x), .player_y(player_y), .player_colour(player_colour),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .frame_index(frame_index), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Dual-port tile BRAM: port A writes, port B reads with one-cycle latency.
  logic [2:0] bram [16];
  always @(posedge clock) begin
    if (wr_en) bram[wr_addr] <= wr_data;
    if (rd_en) rd_data <= bram[rd_addr];
  end

  typedef struct {
    logic [3:0] p0x, p0y, p1x, p1y;
    logic [2:0] c0, c1;
    logic       hold;
    logic       en   [4];
    logic [3:0] addr [4];
    logic [2:0] data [4];
  } vec_t;

  vec_t tbl [7];
  logic [2:0] exp_mem [16];
  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Addresses < 0 mean "no write expected"; erase data is always background.
  function automatic vec_t mk(input int x0, y0, c0, x1, y1, c1,
                              input int e0a, e1a, w0a, w1a, w0d, w1d);
    vec_t r;
    int a [4];
    a = '{e0a, e1a, w0a, w1a};
    r.p0x = 4'(x0);  r.p0y = 4'(y0);  r.c0 = 3'(c0);
    r.p1x = 4'(x1);  r.p1y = 4'(y1);  r.c1 = 3'(c1);
    r.hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      r.en[k]   = (a[k] >= 0);
      r.addr[k] = (a[k] >= 0) ? 4'(a[k]) : 4'd0;
    end
    r.data[0] = 3'd0;  r.data[1] = 3'd0;
    r.data[2] = 3'(w0d);  r.data[3] = 3'(w1d);
    return r;
  endfunction

  task automatic run_seq(input vec_t v);
    int c, n, stray, idle_gap, m, tile, pix, ex, ey;
    bit seen;
    for (int k = 0; k < 4; k++) if (v.en[k]) exp_mem[v.addr[k]] = v.data[k];
    @(negedge clock);
    player_x = {v.p1x, v.p0x};  player_y = {v.p1y, v.p0y};
    player_colour = {v.c1, v.c0};
    start = 1'b1;
    @(negedge clock);
    chk("latch_busy", busy, 1);
    if (!v.hold) start = 1'b0;
    c = 0;  n = 0;  stray = 0;  idle_gap = 0;  seen = 1'b0;
    while (!seen && c < SEQ_LEN + 50) begin
      if (c == 1) begin
        player_x = ~player_x;  player_y = ~player_y;  player_colour = ~player_colour;
      end
      if (c == 5) begin
        player_x = {v.p1x, v.p0x};  player_y = {v.p1y, v.p0y};
        player_colour = {v.c1, v.c0};
        chk("fetch0_rd_en", rd_en, 1);
        chk("fetch0_rd_addr", rd_addr, 0);
      end
      if (c >= 1 && c <= 4) begin
        chk($sformatf("wr_en[%0d]", c-1), wr_en, v.en[c-1]);
        if (v.en[c-1]) begin
          chk($sformatf("wr_addr[%0d]", c-1), wr_addr, v.addr[c-1]);
          chk($sformatf("wr_data[%0d]", c-1), wr_data, v.data[c-1]);
        end
        if (rd_en) stray++;
      end else if (wr_en) stray++;
      if (plot) begin
        m = n % (GW*GH*TP*TP);
        tile = m / (TP*TP);  pix = m % (TP*TP);
        ex = (tile % GW)*TP + pix % TP;
        ey = (tile / GW)*TP + pix / TP;
        chk("plot_x", x, ex);
        chk("plot_y", y, ey);
        chk("plot_colour", colour, exp_mem[tile]);
        chk("plot_frame", frame_index, n / (GW*GH*TP*TP));
        n++;
      end
      if (!busy) idle_gap++;
      if (done) begin
        seen = 1'b1;
        chk("seq_len", c + 1, SEQ_LEN);
        chk("plot_count", n, PLOTS);
        chk("done_frame_index", frame_index, NF);
      end else begin
        @(negedge clock);
        c++;
      end
    end
    chk("seq_done_seen", seen, 1);
    chk("stray_port_activity", stray, 0);
    chk("busy_gaps", idle_gap, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, nplots, nbusy;
    for (int i = 0; i < 16; i++) begin
      bram[i] = 3'd0;
      exp_mem[i] = 3'd0;
    end
    rd_data = 3'd0;
    reset = 1'b1;  start = 1'b0;
    player_x = '0;  player_y = '0;  player_colour = '0;

    tbl[0] = mk(1,0,4, 2,3,1,   -1,-1,  1,14, 4,1);  // basic
    tbl[1] = mk(0,0,4, 2,3,1,    1,14,  0,14, 4,1);  // P0 moved
    tbl[2] = mk(3,3,2, 3,3,1,    0,14, 15,15, 7,7);  // collision
    tbl[3] = mk(0,1,6, 4,0,3,   15,15,  4,-1, 6,0);  // P1 out of range
    tbl[4] = mk(1,1,5, 1,2,2,    4,-1,  5, 9, 5,2);  // erase skips invalid P1
    tbl[5] = mk(2,2,4, 3,0,3,    5, 9, 10, 3, 4,3);  // start held high
    tbl[5].hold = 1'b1;
    tbl[6] = mk(0,3,6, 3,3,5,   -1,-1, 12,15, 6,5);  // after reset mid-draw

    @(negedge clock);
    @(negedge clock);
    chk("reset_outputs", {wr_en, wr_addr, wr_data, rd_en, rd_addr, x, y, colour,
                          plot, frame_index, busy, done}, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 6; i++) run_seq(tbl[i]);

    // start still high: one idle cycle, then a fresh LATCH
    @(negedge clock);
    chk("idle_after_done_busy", busy, 0);
    chk("idle_after_done_frame", frame_index, 0);
    chk("idle_after_done_done", done, 0);
    @(negedge clock);
    chk("relatch_busy", busy, 1);
    start = 1'b0;

    w = 0;
    while (!(plot && frame_index == 2'd1) && w < SEQ_LEN + 50) begin
      @(negedge clock);
      w++;
    end
    chk("reach_frame1_plot", plot && frame_index == 2'd1, 1);
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {wr_en, wr_addr, wr_data, rd_en, rd_addr, x, y, colour,
                                plot, frame_index, busy, done}, 0);
    @(negedge clock);
    reset = 1'b0;
    nplots = 0;  nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (plot) nplots++;
      if (busy) nbusy++;
    end
    chk("post_reset_plots", nplots, 0);
    chk("post_reset_busy", nbusy, 0);

    run_seq(tbl[6]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
